// File: rtl/trdb_filter_multi.sv
// Trace-encoder instruction filter with NUM_CMP programmable comparators and a
// start/stop trace window. All outputs are registered one cycle after the instruction.

package trdb_pkg;
  localparam int XLEN      = 32;
  localparam int CAUSE_LEN = 5;
  localparam int PRIV_LEN  = 2;

  typedef enum logic [2:0] {
    SRC_CAUSE = 3'd0,
    SRC_TVEC  = 3'd1,
    SRC_TVAL  = 3'd2,
    SRC_PRIV  = 3'd3,
    SRC_IADDR = 3'd4
  } cmp_src_e;

  typedef enum logic [1:0] {
    ROLE_QUAL  = 2'd0,
    ROLE_START = 2'd1,
    ROLE_STOP  = 2'd2,
    ROLE_RSVD  = 2'd3
  } cmp_role_e;

  typedef enum logic {
    MODE_MATCH = 1'b0,
    MODE_RANGE = 1'b1
  } cmp_mode_e;

  typedef enum logic {
    WIN_CLOSED = 1'b0,
    WIN_OPEN   = 1'b1
  } win_state_e;
endpackage

module trdb_filter_multi #(
  parameter int NUM_CMP   = 4,
  parameter int XLEN      = trdb_pkg::XLEN,
  parameter int CAUSE_LEN = trdb_pkg::CAUSE_LEN,
  parameter int PRIV_LEN  = trdb_pkg::PRIV_LEN,
  parameter int IDX_W     = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trace_enable_i,
  input  logic                 valid_i,
  input  logic [CAUSE_LEN-1:0] cause_i,
  input  logic [XLEN-3:0]      tvec_i,
  input  logic [XLEN-1:0]      tval_i,
  input  logic [PRIV_LEN-1:0]  priv_lvl_i,
  input  logic [XLEN-1:0]      iaddr_i,
  input  logic                 cfg_we_i,
  input  logic [IDX_W-1:0]     cfg_idx_i,
  input  logic                 cfg_en_i,
  input  logic [2:0]           cfg_src_i,
  input  logic                 cfg_mode_i,
  input  logic [1:0]           cfg_role_i,
  input  logic [XLEN-1:0]      cfg_lower_i,
  input  logic [XLEN-1:0]      cfg_upper_i,
  input  logic                 window_mode_i,
  output logic                 nc_qualified_o,
  output logic                 qualified_valid_o,
  output logic                 window_open_o,
  output logic [NUM_CMP-1:0]   hit_o
);

  import trdb_pkg::*;

  typedef struct packed {
    logic            en;
    logic [2:0]      src;
    logic            mode;
    logic [1:0]      role;
    logic [XLEN-1:0] lower;
    logic [XLEN-1:0] upper;
  } cmp_cfg_t;

  cmp_cfg_t     cfg_q [NUM_CMP];
  cmp_cfg_t     cfg_d [NUM_CMP];
  win_state_e   state_q, state_d;
  logic         nc_qualified_q, nc_qualified_d;
  logic         qualified_valid_q, qualified_valid_d;
  logic [NUM_CMP-1:0] hit_q, hit_d;

  logic [XLEN-1:0]    operand [NUM_CMP];
  logic [NUM_CMP-1:0] src_ok;
  logic [NUM_CMP-1:0] cmp_ok;
  logic [NUM_CMP-1:0] raw_hit;
  logic               qual;
  logic               start_hit;
  logic               stop_hit;
  logic               in_window;
  logic               advance;

  // Config write: comparisons in the write cycle still see cfg_q; an index with no
  // matching entry falls through the loop and is dropped.
  always_comb begin
    // NOTE: every always_comb target gets a default before any branch so no latch is inferred.
    cfg_d = cfg_q;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (cfg_we_i && (cfg_idx_i == IDX_W'(k))) begin
        cfg_d[k].en    = cfg_en_i;
        cfg_d[k].src   = cfg_src_i;
        cfg_d[k].mode  = cfg_mode_i;
        cfg_d[k].role  = cfg_role_i;
        cfg_d[k].lower = cfg_lower_i;
        cfg_d[k].upper = cfg_upper_i;
      end
    end
  end

  // Per-comparator operand select and compare; reserved sources and roles never hit.
  always_comb begin
    for (int k = 0; k < NUM_CMP; k++) begin
      operand[k] = '0;
      src_ok[k]  = 1'b1;
      unique case (cfg_q[k].src)
        SRC_CAUSE: operand[k] = XLEN'(cause_i);
        SRC_TVEC:  operand[k] = {tvec_i, 2'b00};
        SRC_TVAL:  operand[k] = tval_i;
        SRC_PRIV:  operand[k] = XLEN'(priv_lvl_i);
        SRC_IADDR: operand[k] = iaddr_i;
        default:   src_ok[k]  = 1'b0;
      endcase

      if (cfg_q[k].mode == MODE_RANGE) begin
        cmp_ok[k] = (operand[k] >= cfg_q[k].lower) && (operand[k] <= cfg_q[k].upper);
      end else begin
        cmp_ok[k] = (operand[k] == cfg_q[k].lower);
      end

      raw_hit[k] = cfg_q[k].en && valid_i && src_ok[k] && cmp_ok[k] &&
                   (cfg_q[k].role != ROLE_RSVD);
    end
  end

  // Qualify comparators are ANDed (vacuously true when none is enabled);
  // start/stop comparators are ORed.
  always_comb begin
    qual      = 1'b1;
    start_hit = 1'b0;
    stop_hit  = 1'b0;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (cfg_q[k].en && (cfg_q[k].role == ROLE_QUAL) && !raw_hit[k]) begin
        qual = 1'b0;
      end
      if (cfg_q[k].role == ROLE_START) start_hit = start_hit | raw_hit[k];
      if (cfg_q[k].role == ROLE_STOP)  stop_hit  = stop_hit  | raw_hit[k];
    end
  end

  // Window FSM next state.
  always_comb begin
    state_d = state_q;
    advance = valid_i && trace_enable_i && window_mode_i;
    if (!window_mode_i || !trace_enable_i) begin
      state_d = WIN_CLOSED;
    end else if (advance) begin
      unique case (state_q)
        WIN_CLOSED: if (start_hit && !stop_hit) state_d = WIN_OPEN;
        WIN_OPEN:   if (stop_hit)               state_d = WIN_CLOSED;
        default:    state_d = WIN_CLOSED;
      endcase
    end
  end

  // A start instruction is inside its own window; a stop instruction is inside
  // the window it closes because OPEN is still the registered state.
  always_comb begin
    in_window         = !window_mode_i || (state_q == WIN_OPEN) || start_hit;
    nc_qualified_d    = valid_i && trace_enable_i && qual && in_window;
    qualified_valid_d = valid_i && trace_enable_i;
    hit_d             = raw_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= WIN_CLOSED;
      nc_qualified_q    <= 1'b0;
      qualified_valid_q <= 1'b0;
      hit_q             <= '0;
      // NOTE: the comparator table is reset on purpose; a reset must force software
      // to reprogram the filter before any window can reopen.
      for (int k = 0; k < NUM_CMP; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // the same pre-edge values.
      state_q           <= state_d;
      nc_qualified_q    <= nc_qualified_d;
      qualified_valid_q <= qualified_valid_d;
      hit_q             <= hit_d;
      cfg_q             <= cfg_d;
    end
  end

  assign nc_qualified_o    = nc_qualified_q;
  assign qualified_valid_o = qualified_valid_q;
  assign window_open_o     = (state_q == WIN_OPEN);
  assign hit_o             = hit_q;

endmodule

// File: tb/tb_trdb_filter_multi.sv
// Self-checking bench for trdb_filter_multi: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural model of the filter rules.

module tb_trdb_filter_multi;

  localparam int NUM_CMP = 3;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, te, valid, we, cen, cmode, wmode;
  logic [4:0]          cause;
  logic [29:0]         tvec;
  logic [31:0]         tval, iaddr, clo, chi;
  logic [1:0]          priv, crole;
  logic [IDX_W-1:0]    idx;
  logic [2:0]          csrc;
  logic                nc_qualified_o, qualified_valid_o, window_open_o;
  logic [NUM_CMP-1:0]  hit_o;

  trdb_filter_multi #(.NUM_CMP(NUM_CMP)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .trace_enable_i   (te),
    .valid_i          (valid),
    .cause_i          (cause),
    .tvec_i           (tvec),
    .tval_i           (tval),
    .priv_lvl_i       (priv),
    .iaddr_i          (iaddr),
    .cfg_we_i         (we),
    .cfg_idx_i        (idx),
    .cfg_en_i         (cen),
    .cfg_src_i        (csrc),
    .cfg_mode_i       (cmode),
    .cfg_role_i       (crole),
    .cfg_lower_i      (clo),
    .cfg_upper_i      (chi),
    .window_mode_i    (wmode),
    .nc_qualified_o   (nc_qualified_o),
    .qualified_valid_o(qualified_valid_o),
    .window_open_o    (window_open_o),
    .hit_o            (hit_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit        en;
    int        src;
    bit        range;
    int        role;
    bit [31:0] lo;
    bit [31:0] hi;
  } mcfg_t;

  mcfg_t m_cfg [NUM_CMP];
  bit    m_open;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the comparator sees for a given source; returns 0 with ok=0 for reserved sources.
  function automatic bit [31:0] m_operand(input int src, output bit ok);
    bit [31:0] t;
    ok = 1'b1;
    case (src)
      0: return 32'(cause);
      1: begin t = 32'(tvec); return t * 4; end
      2: return tval;
      3: return 32'(priv);
      4: return iaddr;
      default: begin ok = 1'b0; return 0; end
    endcase
  endfunction

  function automatic bit m_hit(input int k);
    bit ok;
    bit [31:0] op;
    op = m_operand(m_cfg[k].src, ok);
    if (!m_cfg[k].en || !valid || !ok || m_cfg[k].role == 3) return 1'b0;
    if (m_cfg[k].range) return (m_cfg[k].lo <= op) && (op <= m_cfg[k].hi);
    return op == m_cfg[k].lo;
  endfunction

  // Apply one clock with the currently driven inputs and compare all outputs.
  task automatic step();
    bit [NUM_CMP-1:0] eh;
    bit q, st, sp, inwin, nopen, e_nc, e_qv;
    eh = '0; q = 1'b1; st = 1'b0; sp = 1'b0;
    for (int k = 0; k < NUM_CMP; k++) begin
      eh[k] = m_hit(k);
      if (m_cfg[k].en && m_cfg[k].role == 0 && !eh[k]) q = 1'b0;
      if (m_cfg[k].role == 1 && eh[k]) st = 1'b1;
      if (m_cfg[k].role == 2 && eh[k]) sp = 1'b1;
    end
    inwin = !wmode || m_open || st;
    e_nc  = valid && te && q && inwin;
    e_qv  = valid && te;
    if (!wmode || !te)             nopen = 1'b0;
    else if (!valid)               nopen = m_open;
    else if (!m_open && st && !sp) nopen = 1'b1;
    else if (m_open && sp)         nopen = 1'b0;
    else                           nopen = m_open;
    if (rst) begin
      eh = '0; e_nc = 1'b0; e_qv = 1'b0; nopen = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < NUM_CMP; k++) m_cfg[k] = '{0, 0, 0, 0, 0, 0};
    end else if (we && int'(idx) < NUM_CMP) begin
      m_cfg[idx] = '{cen, int'(csrc), cmode, int'(crole), clo, chi};
    end
    m_open = nopen;
    check("nc_qualified", 32'(nc_qualified_o), 32'(e_nc));
    check("qualified_valid", 32'(qualified_valid_o), 32'(e_qv));
    check("window_open", 32'(window_open_o), 32'(m_open));
    check("hit", 32'(hit_o), 32'(eh));
  endtask

  task automatic write_cfg(input int i, input bit e, input int s, input bit md,
                           input int r, input bit [31:0] lo, input bit [31:0] hi);
    we = 1'b1; idx = IDX_W'(i); cen = e; csrc = 3'(s); cmode = md; crole = 2'(r);
    clo = lo; chi = hi;
    step();
    we = 1'b0;
  endtask

  task automatic instr(input bit [31:0] a);
    valid = 1'b1; iaddr = a;
    step();
  endtask

  initial begin
    for (int k = 0; k < NUM_CMP; k++) m_cfg[k] = '{0, 0, 0, 0, 0, 0};
    m_open = 1'b0;
    rst = 1'b1; te = 1'b0; valid = 1'b0; we = 1'b0; cen = 1'b0; cmode = 1'b0; wmode = 1'b0;
    cause = '0; tvec = '0; tval = '0; iaddr = '0; clo = '0; chi = '0; priv = '0;
    crole = '0; idx = '0; csrc = '0;

    // Reset state
    step();
    step();
    check("reset_nc", 32'(nc_qualified_o), 32'd0);
    check("reset_open", 32'(window_open_o), 32'd0);
    rst = 1'b0;

    // No comparator, window always open: every instruction qualified
    te = 1'b1; wmode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr($urandom);
      check("pass_all_nc", 32'(nc_qualified_o), 32'd1);
      check("pass_all_qv", 32'(qualified_valid_o), 32'd1);
    end

    // Range qualify on iaddr 0x1000..0x1FFF, boundaries on both sides
    valid = 1'b0;
    write_cfg(0, 1, 4, 1, 0, 32'h1000, 32'h1FFF);
    instr(32'h0FFC); check("range_below", 32'(nc_qualified_o), 32'd0);
    instr(32'h1000); check("range_lower", 32'(nc_qualified_o), 32'd1);
    check("range_lower_hit", 32'(hit_o[0]), 32'd1);
    instr(32'h1FFF); check("range_upper", 32'(nc_qualified_o), 32'd1);
    instr(32'h2000); check("range_above", 32'(nc_qualified_o), 32'd0);
    check("range_above_hit", 32'(hit_o[0]), 32'd0);

    // Start/stop window: start 0x80, stop 0x90, inclusive
    valid = 1'b0;
    write_cfg(0, 0, 4, 1, 0, 32'h1000, 32'h1FFF);
    wmode = 1'b1;
    write_cfg(1, 1, 4, 0, 1, 32'h80, 32'h0);
    write_cfg(2, 1, 4, 0, 2, 32'h90, 32'h0);
    instr(32'h70); check("win_before", 32'(nc_qualified_o), 32'd0);
    instr(32'h80); check("win_start", 32'(nc_qualified_o), 32'd1);
    check("win_start_open", 32'(window_open_o), 32'd1);
    instr(32'h84); check("win_inside", 32'(nc_qualified_o), 32'd1);
    instr(32'h90); check("win_stop", 32'(nc_qualified_o), 32'd1);
    check("win_stop_closed", 32'(window_open_o), 32'd0);
    instr(32'h94); check("win_after", 32'(nc_qualified_o), 32'd0);

    // Start and stop on the same instruction: single shot when closed, close when open
    valid = 1'b0;
    write_cfg(1, 1, 4, 0, 1, 32'hA0, 32'h0);
    write_cfg(2, 1, 4, 0, 2, 32'hA0, 32'h0);
    instr(32'hA0); check("shot_closed_nc", 32'(nc_qualified_o), 32'd1);
    check("shot_closed_open", 32'(window_open_o), 32'd0);
    valid = 1'b0;
    write_cfg(1, 1, 4, 0, 1, 32'hB0, 32'h0);
    instr(32'hB0); check("reopen", 32'(window_open_o), 32'd1);
    valid = 1'b0;
    write_cfg(1, 1, 4, 0, 1, 32'hA0, 32'h0);
    instr(32'hA0); check("shot_open_nc", 32'(nc_qualified_o), 32'd1);
    check("shot_open_closed", 32'(window_open_o), 32'd0);

    // Config write in the same cycle as an instruction uses the old config
    wmode = 1'b0; valid = 1'b1; priv = 2'd0;
    write_cfg(0, 1, 3, 0, 0, 32'd3, 32'd0);
    check("wr_same_cycle", 32'(nc_qualified_o), 32'd1);
    priv = 2'd0; instr(32'h0); check("wr_new_priv0", 32'(nc_qualified_o), 32'd0);
    priv = 2'd3; instr(32'h0); check("wr_new_priv3", 32'(nc_qualified_o), 32'd1);
    valid = 1'b0;
    write_cfg(3, 1, 3, 0, 0, 32'd1, 32'd0);
    priv = 2'd3; instr(32'h0); check("wr_idx_oob", 32'(nc_qualified_o), 32'd1);

    // Reset while the window is open clears state and config
    valid = 1'b0;
    write_cfg(0, 0, 3, 0, 0, 32'd3, 32'd0);
    wmode = 1'b1;
    write_cfg(1, 1, 4, 0, 1, 32'h80, 32'h0);
    instr(32'h80); check("pre_rst_open", 32'(window_open_o), 32'd1);
    rst = 1'b1; instr(32'h84); rst = 1'b0;
    check("rst_open", 32'(window_open_o), 32'd0);
    check("rst_nc", 32'(nc_qualified_o), 32'd0);
    check("rst_qv", 32'(qualified_valid_o), 32'd0);
    check("rst_hit", 32'(hit_o), 32'd0);
    instr(32'h80); check("post_rst_open", 32'(window_open_o), 32'd0);
    check("post_rst_nc", 32'(nc_qualified_o), 32'd0);

    // Randomized traffic with small operand ranges so hits are frequent
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 79) == 0);
      te    = ($urandom_range(0, 9) != 0);
      wmode = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 3) == 0);
      idx   = IDX_W'($urandom_range(0, 3));
      cen   = ($urandom_range(0, 3) != 0);
      csrc  = 3'($urandom_range(0, 7));
      cmode = 1'($urandom_range(0, 1));
      crole = 2'($urandom_range(0, 3));
      clo   = 32'($urandom_range(0, 15));
      chi   = 32'($urandom_range(0, 15));
      cause = 5'($urandom_range(0, 15));
      tvec  = 30'($urandom_range(0, 3));
      tval  = 32'($urandom_range(0, 15));
      priv  = 2'($urandom_range(0, 3));
      iaddr = 32'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trdb_filter_multi.md
Name: trdb_filter_multi

Overview:
- Parametrised successor of the trace-encoder instruction filter: NUM_CMP runtime-programmable comparators, each bound to one source (cause, tvec, tval, priv_lvl, iaddr), replace the fixed one-comparator-per-source filter.
- Adds a start/stop trace window state machine and registers all outputs.
- Sits between the core trace interface and the packet emitter; the emitter takes nc_qualified_o as its per-instruction qualification.

Parameters:
- NUM_CMP, 4, number of comparators (1..16).
- XLEN, 32, datapath width (trdb_pkg).
- CAUSE_LEN, 5, cause width (trdb_pkg).
- PRIV_LEN, 2, privilege width (trdb_pkg).
- IDX_W, max(1,$clog2(NUM_CMP)), comparator index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- trace_enable_i  in  1  global trace enable.
- valid_i  in  1  instruction retired this cycle.
- cause_i  in  CAUSE_LEN  trap cause.
- tvec_i  in  XLEN-2  trap vector [XLEN-1:2].
- tval_i  in  XLEN  trap value.
- priv_lvl_i  in  PRIV_LEN  privilege level.
- iaddr_i  in  XLEN  instruction address.
- cfg_we_i  in  1  comparator config write strobe.
- cfg_idx_i  in  IDX_W  comparator being written.
- cfg_en_i  in  1  comparator enable.
- cfg_src_i  in  3  source select: 0 cause, 1 tvec, 2 tval, 3 priv, 4 iaddr, 5-7 reserved.
- cfg_mode_i  in  1  0 match, 1 range.
- cfg_role_i  in  2  0 qualify, 1 start, 2 stop, 3 reserved.
- cfg_lower_i  in  XLEN  lower bound, or match value in match mode.
- cfg_upper_i  in  XLEN  upper bound.
- window_mode_i  in  1  0 window always open, 1 start/stop window.
- nc_qualified_o  out  1  instruction qualified (registered).
- qualified_valid_o  out  1  registered valid_i & trace_enable_i.
- window_open_o  out  1  FSM state == OPEN.
- hit_o  out  NUM_CMP  per-comparator hit (registered).

Behaviour:
- Reset values: config registers all en=0, src=0, mode=0, role=0, bounds=0; FSM CLOSED; all outputs 0.
- Config writes:
  - On a cfg_we_i edge, entry cfg_idx_i is loaded.
  - cfg_idx_i >= NUM_CMP is ignored.
  - Comparisons in the write cycle use the old config; the new value applies from the next cycle.
- Source operand is zero-extended to XLEN. tvec is presented as {tvec_i,2'b00}.
- Comparator hit:
  - Match mode: operand == lower.
  - Range mode: lower <= operand <= upper, unsigned and inclusive. lower > upper never hits.
  - Reserved src or reserved role: never hits.
  - raw_hit[k] = en[k] & valid_i & compare result.
- qual = AND of raw_hit over enabled role-0 comparators; qual = 1 when no role-0 comparator is enabled.
- start_hit = OR of raw_hit over role-1 comparators; stop_hit = OR of raw_hit over role-2 comparators.
- Window FSM (advances only when valid_i & trace_enable_i & window_mode_i; otherwise holds):
  - CLOSED, start & !stop -> OPEN.
  - CLOSED, start & stop -> stays CLOSED; this instruction is in-window (single shot).
  - OPEN, stop -> CLOSED; the stopping instruction is in-window (inclusive).
  - OPEN, start only -> stays OPEN.
- Forced close: window_mode_i=0 or trace_enable_i=0 forces CLOSED on the next edge, overriding all transitions.
- in_window for the current cycle:
  - 1 if window_mode_i=0.
  - Otherwise (state==OPEN) | start_hit.
  - A start instruction is itself qualified.
- Outputs, one-cycle latency: at edge t+1 the outputs reflect cycle-t inputs.
  - nc_qualified_o <= valid_i & trace_enable_i & qual & in_window.
  - qualified_valid_o <= valid_i & trace_enable_i.
  - hit_o <= raw_hit.
  - window_open_o reflects the registered state.
- rst_i mid-window: next cycle CLOSED and all outputs 0. Config is cleared, so a new start is required.
- valid_i=0: nc_qualified_o and hit_o are 0 next cycle; FSM holds.

Test Plan:
- No comparator enabled, window_mode_i=0, trace_enable_i=1, valid_i=1 for 3 cycles -> nc_qualified_o=1 on cycles 2-4; qualified_valid_o=1 on the same cycles.
- cmp0 = qualify, range, iaddr, 0x1000..0x1FFF; iaddr sequence 0x0FFC, 0x1000, 0x1FFF, 0x2000 -> nc_qualified_o = 0,1,1,0 (one cycle later); hit_o[0] matches.
- window_mode_i=1; cmp1 = start, match iaddr 0x80; cmp2 = stop, match iaddr 0x90; iaddr 0x70, 0x80, 0x84, 0x90, 0x94 -> nc_qualified_o = 0,1,1,1,0; window_open_o high after 0x80 and low after 0x90.
- Start and stop both matching iaddr 0xA0 while CLOSED -> that instruction qualified, window_open_o stays 0. The same case while OPEN -> qualified, window closes.
- Write cmp0 (qualify, match priv=3) in the same cycle as valid_i with priv=0 -> old config applies that cycle (qualified); next instruction with priv=0 -> not qualified, priv=3 -> qualified.
- Window OPEN, assert rst_i for 1 cycle -> all outputs 0, window_open_o=0. Then with valid_i=1 and any iaddr -> window_open_o stays 0 until reprogrammed.
